// File: rtl/k8088_memctl.sv
// k8088 byte-bus responder: serves each CPU bus cycle from a 16-bit async SRAM.
// Define K8088_MEMCTL_WORDBUF_EN to add a one-entry sibling-byte read buffer.
`timescale 1ns/1ps
module k8088_memctl #(
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        cpu_chipen,
   output logic [18:0] sram_a,
   output logic [15:0] sram_d_o,
   input  logic [15:0] sram_d_i,
   output logic        sram_d_oe,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_lb_n,
   output logic        sram_ub_n
);

   localparam logic [1:0] S_START = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

   logic [1:0]  state_q,  state_d;
   logic [3:0]  cnt_q,    cnt_d;
   logic        lane_q,   lane_d;
   logic        we_q,     we_d;
   logic [7:0]  cpu_in_q, cpu_in_d;
   logic        chipen_q, chipen_d;
   logic [18:0] sram_a_q, sram_a_d;
   logic [15:0] d_o_q,    d_o_d;
   logic        d_oe_q,   d_oe_d;
   logic        oe_n_q,   oe_n_d;
   logic        we_n_q,   we_n_d;
   logic        lb_n_q,   lb_n_d;
   logic        ub_n_q,   ub_n_d;
   logic        buf_hit;

`ifdef K8088_MEMCTL_WORDBUF_EN
   logic        buf_valid_q, buf_valid_d;
   logic [18:0] buf_word_q,  buf_word_d;
   logic        buf_lane_q,  buf_lane_d;
   logic [7:0]  buf_byte_q,  buf_byte_d;

   assign buf_hit = !cpu_we && buf_valid_q && (buf_word_q == cpu_address[19:1])
                    && (buf_lane_q == cpu_address[0]);
`else
   assign buf_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lane_d   = lane_q;
      we_d     = we_q;
      cpu_in_d = cpu_in_q;
      chipen_d = chipen_q;
      sram_a_d = sram_a_q;
      d_o_d    = d_o_q;
      d_oe_d   = d_oe_q;
      oe_n_d   = oe_n_q;
      we_n_d   = we_n_q;
      lb_n_d   = lb_n_q;
      ub_n_d   = ub_n_q;
`ifdef K8088_MEMCTL_WORDBUF_EN
      buf_valid_d = buf_valid_q;
      buf_word_d  = buf_word_q;
      buf_lane_d  = buf_lane_q;
      buf_byte_d  = buf_byte_q;
`endif
      case (state_q)
         S_START: begin
            if (buf_hit) begin
`ifdef K8088_MEMCTL_WORDBUF_EN
               cpu_in_d = buf_byte_q;
`endif
               chipen_d = 1'b1;
               state_d  = S_READY;
            end else begin
               lane_d   = cpu_address[0];
               we_d     = cpu_we;
               sram_a_d = cpu_address[19:1];
               lb_n_d   = cpu_address[0];
               ub_n_d   = ~cpu_address[0];
               cnt_d    = '0;
               state_d  = S_WAIT;
               if (cpu_we) begin
                  d_oe_d = 1'b1;
                  d_o_d  = {cpu_out, cpu_out};
                  we_n_d = 1'b0;
`ifdef K8088_MEMCTL_WORDBUF_EN
                  // A write to the buffered word makes the sibling byte stale.
                  if (buf_word_q == cpu_address[19:1])
                     buf_valid_d = 1'b0;
`endif
               end else begin
                  oe_n_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == WS_LAST) begin
               state_d  = S_READY;
               chipen_d = 1'b1;
               oe_n_d   = 1'b1;
               we_n_d   = 1'b1;
               lb_n_d   = 1'b1;
               ub_n_d   = 1'b1;
               if (!we_q) begin
                  cpu_in_d = lane_q ? sram_d_i[15:8] : sram_d_i[7:0];
`ifdef K8088_MEMCTL_WORDBUF_EN
                  buf_valid_d = 1'b1;
                  buf_word_d  = sram_a_q;
                  buf_lane_d  = ~lane_q;
                  buf_byte_d  = lane_q ? sram_d_i[7:0] : sram_d_i[15:8];
`endif
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_READY: begin
            chipen_d = 1'b0;
            d_oe_d   = 1'b0;
            state_d  = S_START;
         end
         default: state_d = S_START;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_START;
         cnt_q    <= '0;
         lane_q   <= 1'b0;
         we_q     <= 1'b0;
         cpu_in_q <= '0;
         chipen_q <= 1'b0;
         sram_a_q <= '0;
         d_o_q    <= '0;
         d_oe_q   <= 1'b0;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         lb_n_q   <= 1'b1;
         ub_n_q   <= 1'b1;
`ifdef K8088_MEMCTL_WORDBUF_EN
         buf_valid_q <= 1'b0;
         buf_word_q  <= '0;
         buf_lane_q  <= 1'b0;
         buf_byte_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lane_q   <= lane_d;
         we_q     <= we_d;
         cpu_in_q <= cpu_in_d;
         chipen_q <= chipen_d;
         sram_a_q <= sram_a_d;
         d_o_q    <= d_o_d;
         d_oe_q   <= d_oe_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         lb_n_q   <= lb_n_d;
         ub_n_q   <= ub_n_d;
`ifdef K8088_MEMCTL_WORDBUF_EN
         buf_valid_q <= buf_valid_d;
         buf_word_q  <= buf_word_d;
         buf_lane_q  <= buf_lane_d;
         buf_byte_q  <= buf_byte_d;
`endif
      end
   end

   assign cpu_in     = cpu_in_q;
   assign cpu_chipen = chipen_q;
   assign sram_a     = sram_a_q;
   assign sram_d_o   = d_o_q;
   assign sram_d_oe  = d_oe_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_lb_n  = lb_n_q;
   assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_k8088_memctl.sv
// Directed bench for k8088_memctl (WAIT_STATES 2, plus 1 and 15 instances).
// Buffer-hit expectations follow K8088_MEMCTL_WORDBUF_EN.
`timescale 1ns/1ps
module tb_k8088_memctl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [19:0] cpu_address = '0;
   logic [7:0]  cpu_out = '0;
   logic        cpu_we = 1'b0;

   logic [7:0]  cpu_in;
   logic        cpu_chipen;
   logic [18:0] sram_a;
   logic [15:0] sram_d_o, sram_d_i;
   logic        sram_d_oe, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   logic [7:0]  cpu_in_1, cpu_in_15;
   logic        chipen_1, chipen_15;
   logic [18:0] a_1, a_15;
   logic [15:0] do_1, do_15, di_1, di_15;
   logic        doe_1, oen_1, wen_1, lbn_1, ubn_1;
   logic        doe_15, oen_15, wen_15, lbn_15, ubn_15;

   int n_vec = 0;
   int n_miss = 0;

   always #20 clock = ~clock;

   k8088_memctl #(.WAIT_STATES(2)) dut (
      .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_chipen(cpu_chipen), .sram_a(sram_a),
      .sram_d_o(sram_d_o), .sram_d_i(sram_d_i), .sram_d_oe(sram_d_oe), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n));

   k8088_memctl #(.WAIT_STATES(1)) dut_ws1 (
      .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(cpu_in_1), .cpu_chipen(chipen_1), .sram_a(a_1),
      .sram_d_o(do_1), .sram_d_i(di_1), .sram_d_oe(doe_1), .sram_oe_n(oen_1),
      .sram_we_n(wen_1), .sram_lb_n(lbn_1), .sram_ub_n(ubn_1));

   k8088_memctl #(.WAIT_STATES(15)) dut_ws15 (
      .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_we(cpu_we), .cpu_in(cpu_in_15), .cpu_chipen(chipen_15), .sram_a(a_15),
      .sram_d_o(do_15), .sram_d_i(di_15), .sram_d_oe(doe_15), .sram_oe_n(oen_15),
      .sram_we_n(wen_15), .sram_lb_n(lbn_15), .sram_ub_n(ubn_15));

   assign di_1  = {~a_1[7:0], a_1[7:0]};
   assign di_15 = {~a_15[7:0], a_15[7:0]};

   // SRAM model: preset words, overlay of written words; a write lands when WE
   // rises after being low for at least two sampled clocks (minimum pulse width).
   logic [15:0] mem  [0:524287];
   bit          wr_v [0:524287];
   int          wlow = 0;
   logic [18:0] wa;
   logic [15:0] wd;
   logic        wlb, wub;

   function automatic logic [15:0] init_word(input logic [18:0] a);
      case (a)
         19'h7FFF8: return 16'hEA90;
         19'h00080: return 16'h3300;
         19'h00100: return 16'hBEEF;
         19'h00180: return 16'h1234;
         19'h7FFFF: return 16'hC3A5;
         default:   return {~a[7:0], a[7:0]};
      endcase
   endfunction

   function automatic logic [15:0] rd_word(input logic [18:0] a);
      return wr_v[a] ? mem[a] : init_word(a);
   endfunction

   function automatic logic [15:0] merge(input logic [18:0] a, input logic [15:0] d,
                                         input logic lbn, input logic ubn);
      logic [15:0] w;
      w = rd_word(a);
      if (!lbn) w[7:0]  = d[7:0];
      if (!ubn) w[15:8] = d[15:8];
      return w;
   endfunction

   assign sram_d_i = rd_word(sram_a);

   always @(posedge clock) begin
      if (!sram_we_n) begin
         wlow <= wlow + 1;
         wa   <= sram_a;
         wd   <= sram_d_o;
         wlb  <= sram_lb_n;
         wub  <= sram_ub_n;
      end else begin
         if (wlow >= 2) begin
            mem[wa]  <= merge(wa, wd, wlb, wub);
            wr_v[wa] <= 1'b1;
         end
         wlow <= 0;
      end
   end

   // Strobe monitor for the three instances: latency between pulses and back-to-back pulses.
   logic       mon_en = 1'b0;
   logic [2:0] ce, ce_prev = '0;
   int         cyc[3], bad[3], viol[3], pulses[3];
   bit         started[3];
   assign ce = {chipen_15, chipen_1, cpu_chipen};

   initial begin
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 0; bad[i] = 0; viol[i] = 0; pulses[i] = 0; started[i] = 0;
      end
   end

   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (!mon_en) begin
            cyc[i]     <= 0;
            started[i] <= 1'b0;
         end else begin
            if (ce[i] && ce_prev[i]) viol[i] <= viol[i] + 1;
            if (ce[i]) begin
               pulses[i] <= pulses[i] + 1;
               if (started[i] && (cyc[i] + 1 != ((i == 0) ? 4 : (i == 1) ? 3 : 17)))
                  bad[i] <= bad[i] + 1;
               started[i] <= 1'b1;
               cyc[i]     <= 0;
            end else begin
               cyc[i] <= cyc[i] + 1;
            end
         end
      end
      ce_prev <= ce;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Results of the last bus cycle.
   int          lat, oeclk, weclk;
   logic [7:0]  rd;
   logic [18:0] a1;
   logic        lb1, ub1, oe1, doe_rdy, seen;
   logic [15:0] do1;

   // Runs one CPU bus cycle starting with the DUT in START; returns one clock after READY.
   task automatic bus(input logic [19:0] a, input logic we, input logic [7:0] d);
      cpu_address = a; cpu_we = we; cpu_out = d;
      lat = 0; oeclk = 0; weclk = 0; seen = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (n == 1) begin
            a1 = sram_a; lb1 = sram_lb_n; ub1 = sram_ub_n; oe1 = sram_oe_n; do1 = sram_d_o;
         end
         if (!sram_oe_n) oeclk++;
         if (!sram_we_n) weclk++;
         if (cpu_chipen) begin
            seen = 1'b1; lat = n + 1; rd = cpu_in; doe_rdy = sram_d_oe;
         end
      end
      chk("chipen_seen", seen, 1);
      @(posedge clock); #1;
      cpu_we = 1'b0;
   endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      cpu_address = 20'hFFFF0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_outputs", {cpu_chipen, cpu_in, sram_a, sram_d_o, sram_d_oe, sram_oe_n,
                          sram_we_n, sram_lb_n, sram_ub_n},
          {1'b0, 8'h00, 19'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
      reset_n = 1'b1;

      // Reset-vector fetch
      bus(20'hFFFF0, 1'b0, 8'h00);
      chk("t1_strobes", {a1, lb1, ub1, oe1}, {19'h7FFF8, 1'b0, 1'b1, 1'b0});
      chk("t1_data", rd, 8'h90);
      chk("t1_latency", lat, 4);

      // Write to odd byte, then read back
      bus(20'h00101, 1'b1, 8'h5A);
      chk("t2_lanes", {lb1, ub1, oe1}, {1'b1, 1'b0, 1'b1});
      chk("t2_d_o", do1, 16'h5A5A);
      chk("t2_we_clocks", weclk, 2);
      chk("t2_doe_ready", doe_rdy, 1);
      chk("t2_latency", lat, 4);
      chk("t2_doe_after", sram_d_oe, 0);
      chk("t2_cpu_in_hold", cpu_in, 8'h90);
      chk("t2_sram_word", rd_word(19'h00080), 16'h5A00);
      bus(20'h00101, 1'b0, 8'h00);
      chk("t2_readback", rd, 8'h5A);

      // Sibling-byte reads
      bus(20'h00200, 1'b0, 8'h00);
      chk("t3_miss", {lat[7:0], rd, oeclk[7:0]}, {8'd4, 8'hEF, 8'd2});
      bus(20'h00201, 1'b0, 8'h00);
`ifdef K8088_MEMCTL_WORDBUF_EN
      chk("t3_hit", {lat[7:0], rd, oeclk[7:0]}, {8'd2, 8'hBE, 8'd0});
      bus(20'h00201, 1'b0, 8'h00);
      chk("t3_hit_again", {lat[7:0], rd, oeclk[7:0]}, {8'd2, 8'hBE, 8'd0});
`else
      chk("t3_sibling", {lat[7:0], rd, oeclk[7:0]}, {8'd4, 8'hBE, 8'd2});
`endif

      // Write invalidates the sibling byte
      bus(20'h00200, 1'b0, 8'h00);
      chk("t4_read", {lat[7:0], rd}, {8'd4, 8'hEF});
      bus(20'h00201, 1'b1, 8'h11);
      bus(20'h00201, 1'b0, 8'h00);
      chk("t4_after_write", {lat[7:0], rd, oeclk[7:0]}, {8'd4, 8'h11, 8'd2});

      // Top of address space
      bus(20'hFFFFF, 1'b0, 8'h00);
      chk("t5_top", {a1, lb1, ub1, rd}, {19'h7FFFF, 1'b1, 1'b0, 8'hC3});

      // Reset during WAIT of a write
      cpu_address = 20'h00300; cpu_we = 1'b1; cpu_out = 8'h77;
      @(posedge clock); #1;
      chk("t6_we_low", sram_we_n, 0);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock); #1;
      chk("t6_rst_strobes", {sram_we_n, sram_d_oe, cpu_chipen, cpu_in},
          {1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clock);
      reset_n = 1'b1; cpu_we = 1'b0;
      bus(20'h00300, 1'b0, 8'h00);
      chk("t6_restart", {lat[7:0], rd}, {8'd4, 8'h34});
      chk("t6_sram_word", rd_word(19'h00180), 16'h1234);

      // Random reads at even addresses on all three instances
      @(negedge clock);
      mon_en = 1'b1;
      repeat (17300) begin
         @(negedge clock);
         cpu_address = {19'($urandom), 1'b0};
      end
      mon_en = 1'b0;
      @(negedge clock);
      chk("rnd_lat_ws2", bad[0], 0);
      chk("rnd_lat_ws1", bad[1], 0);
      chk("rnd_lat_ws15", bad[2], 0);
      chk("rnd_b2b_ws2", viol[0], 0);
      chk("rnd_b2b_ws1", viol[1], 0);
      chk("rnd_b2b_ws15", viol[2], 0);
      chk("rnd_pulses_ws15", (pulses[2] >= 1000), 1);
      chk("rnd_pulses_ws1", (pulses[1] >= 5000), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
